interrupt_controller: RTL and testbench

- Generates the `intSig` redirect request consumed by the program counter and owns the interrupt return path.
- Latches external interrupt requests and applies mask, global enable and priority.
- Issues a one-cycle redirect to the fixed handler vector and captures the interrupted address (EPC) and cause.
- On return-from-interrupt, supplies the return address to the core's jump-register address path.

---
 rtl/interrupt_controller.sv | 167 ++++++++++++++++
 tb/tb_interrupt_controller.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose:
//   Latches rising edges on the external interrupt lines and applies the
//   per-line mask, the global enable and a fixed lowest-index-wins priority.
//   When an interrupt is taken it issues a one-cycle PC redirect (intSig) to
//   the handler vector, then captures the interrupted PC (epc) and the line
//   index (cause). On return-from-interrupt it pulses ret_valid for one cycle,
//   and the core jumps to ret_addr (= epc).
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   synchronous, active-high; clears all state
//   irq          in   [NUM_IRQ]  request lines, synchronous, rising-edge sensitive
//   pc_addr      in   [ADDR_W]   current PC, captured into epc on entry
//   int_en_set   in   enable-interrupts strobe
//   int_en_clr   in   disable-interrupts strobe (wins over set)
//   mask_we      in   mask write strobe
//   mask_wdata   in   [NUM_IRQ]  new mask, 1 = line allowed
//   pend_clr     in   [NUM_IRQ]  software clear of pending bits
//   eret         in   return-from-interrupt strobe
//   intSig       out  one-cycle redirect of the PC to the vector
//   epc          out  [ADDR_W]   captured interrupted address
//   cause        out  [CAUSE_W]  index of the line being serviced
//   in_service   out  handler active
//   pending      out  [NUM_IRQ]  pending register
//   int_enabled  out  global enable flag
//   ret_valid    out  one-cycle pulse: core must jump to ret_addr
//   ret_addr     out  [ADDR_W]   return address (mirrors epc)
//   vector_addr  out  [ADDR_W]   constant handler vector
// -----------------------------------------------------------------------------
module interrupt_controller #(
  parameter  int NUM_IRQ = 4,
  parameter  int ADDR_W  = 32,
  parameter  int VECTOR  = 213,
  localparam int CAUSE_W = $clog2(NUM_IRQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [ADDR_W-1:0]  pc_addr,
  input  logic               int_en_set,
  input  logic               int_en_clr,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [NUM_IRQ-1:0] pend_clr,
  input  logic               eret,
  output logic               intSig,
  output logic [ADDR_W-1:0]  epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] pending,
  output logic               int_enabled,
  output logic               ret_valid,
  output logic [ADDR_W-1:0]  ret_addr,
  output logic [ADDR_W-1:0]  vector_addr
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTER   = 2'd1,
    ST_SERVICE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [NUM_IRQ-1:0] irq_prev_q;
  logic [NUM_IRQ-1:0] pending_q, pending_d;
  logic [NUM_IRQ-1:0] mask_q, mask_d;
  logic               int_en_q, int_en_d;
  logic [ADDR_W-1:0]  epc_q, epc_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;
  logic               ret_valid_q, ret_valid_d;

  logic [NUM_IRQ-1:0] irq_edge;
  logic [NUM_IRQ-1:0] req;
  logic [NUM_IRQ-1:0] take_clr;
  logic [CAUSE_W-1:0] winner;
  logic               fire;

  // irq_prev_q resets to 0, so a line already high when reset drops is seen
  // as an edge in the first cycle out of reset.
  assign irq_edge = irq & ~irq_prev_q;
  assign req      = pending_q & mask_q;

  // An eret cycle never fires, so the earliest re-entry is the cycle after.
  assign fire = int_en_q && (state_q == ST_IDLE) && (|req) && !eret;

  // Lowest-index-wins priority: scan downwards so the last hit is the lowest.
  // NOTE: every signal assigned in an always_comb gets a default first; a
  // path that leaves one unassigned would infer a latch.
  always_comb begin
    winner   = '0;
    take_clr = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) winner = CAUSE_W'(i);
    end
    if (fire) take_clr[winner] = 1'b1;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (fire) state_d = ST_ENTER;
      ST_ENTER:   state_d = ST_SERVICE;
      ST_SERVICE: if (eret) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Datapath next state.
  always_comb begin
    // A new edge wins over a clear in the same cycle; masked lines still latch.
    pending_d   = (pending_q & ~pend_clr & ~take_clr) | irq_edge;
    mask_d      = mask_we ? mask_wdata : mask_q;
    // Clear has priority over set when both strobes arrive together.
    int_en_d    = int_en_clr ? 1'b0 : (int_en_set ? 1'b1 : int_en_q);
    // epc samples the PC during the redirect cycle, verbatim.
    epc_d       = (state_q == ST_ENTER) ? pc_addr : epc_q;
    cause_d     = fire ? winner : cause_q;
    // eret outside SERVICE is ignored and produces no return pulse.
    ret_valid_d = (state_q == ST_SERVICE) && eret;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      irq_prev_q  <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      int_en_q    <= 1'b0;
      epc_q       <= '0;
      cause_q     <= '0;
      ret_valid_q <= 1'b0;
    end else begin
      irq_prev_q  <= irq;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      int_en_q    <= int_en_d;
      epc_q       <= epc_d;
      cause_q     <= cause_d;
      ret_valid_q <= ret_valid_d;
    end
  end

  assign intSig      = (state_q == ST_ENTER);
  assign in_service  = (state_q == ST_SERVICE);
  assign epc         = epc_q;
  assign cause       = cause_q;
  assign pending     = pending_q;
  assign int_enabled = int_en_q;
  assign ret_valid   = ret_valid_q;
  assign ret_addr    = epc_q;
  assign vector_addr = ADDR_W'(VECTOR);

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller. A behavioural model tracks the
// handler phase as two flags (redirect pending / handler running) and
// recomputes pending, mask, enable, epc, cause and the return pulse each
// cycle; every cycle all outputs are compared against it. Directed sequences
// cover the documented scenarios, followed by a randomized run.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int CW = 2;
  localparam int VEC = 213;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  irq;
  logic [AW-1:0] pc_addr;
  logic          int_en_set, int_en_clr, mask_we, eret;
  logic [N-1:0]  mask_wdata, pend_clr;
  logic          intSig, in_service, int_enabled, ret_valid;
  logic [AW-1:0] epc, ret_addr, vector_addr;
  logic [CW-1:0] cause;
  logic [N-1:0]  pending;

  int checks = 0;
  int errors = 0;

  interrupt_controller #(.NUM_IRQ(N), .ADDR_W(AW), .VECTOR(VEC)) dut (
    .clock       (clock),
    .reset       (reset),
    .irq         (irq),
    .pc_addr     (pc_addr),
    .int_en_set  (int_en_set),
    .int_en_clr  (int_en_clr),
    .mask_we     (mask_we),
    .mask_wdata  (mask_wdata),
    .pend_clr    (pend_clr),
    .eret        (eret),
    .intSig      (intSig),
    .epc         (epc),
    .cause       (cause),
    .in_service  (in_service),
    .pending     (pending),
    .int_enabled (int_enabled),
    .ret_valid   (ret_valid),
    .ret_addr    (ret_addr),
    .vector_addr (vector_addr)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  bit [N-1:0]  m_irq_prev, m_pending, m_mask;
  bit          m_en, m_redirect, m_running, m_ret;
  bit [AW-1:0] m_epc;
  int          m_cause;

  function automatic int lowest_set(bit [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_step();
    bit [N-1:0] edges;
    bit [N-1:0] nxt_pend;
    int         win;
    bit         take;
    if (reset) begin
      m_irq_prev = '0; m_pending = '0; m_mask = '0; m_en = 0;
      m_redirect = 0; m_running = 0; m_ret = 0; m_epc = '0; m_cause = 0;
      return;
    end
    edges = irq & ~m_irq_prev;
    win   = lowest_set(m_pending & m_mask);
    take  = m_en && !m_redirect && !m_running && (win >= 0) && !eret;
    nxt_pend = m_pending & ~pend_clr;
    if (take) nxt_pend[win] = 1'b0;
    nxt_pend = nxt_pend | edges;
    m_ret = m_running && eret;
    if (m_redirect) begin
      m_epc      = pc_addr;
      m_redirect = 0;
      m_running  = 1;
    end else if (m_running && eret) begin
      m_running = 0;
    end
    if (take) begin
      m_redirect = 1;
      m_cause    = win;
    end
    m_pending  = nxt_pend;
    if (mask_we) m_mask = mask_wdata;
    if (int_en_clr) m_en = 0;
    else if (int_en_set) m_en = 1;
    m_irq_prev = irq;
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [AW-1:0] got,
                       input logic [AW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("intSig",      AW'(intSig),      AW'(m_redirect));
    check("in_service",  AW'(in_service),  AW'(m_running));
    check("pending",     AW'(pending),     AW'(m_pending));
    check("int_enabled", AW'(int_enabled), AW'(m_en));
    check("epc",         epc,              m_epc);
    check("cause",       AW'(cause),       AW'(m_cause));
    check("ret_valid",   AW'(ret_valid),   AW'(m_ret));
    check("ret_addr",    ret_addr,         m_epc);
    check("vector_addr", vector_addr,      AW'(VEC));
  endtask

  // Inputs are applied at the negedge; one call advances one clock cycle.
  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic idle_inputs();
    int_en_set = 0; int_en_clr = 0; mask_we = 0; mask_wdata = '0;
    pend_clr = '0; eret = 0; reset = 0;
  endtask

  initial begin
    reset = 1; irq = '0; pc_addr = '0;
    int_en_set = 0; int_en_clr = 0; mask_we = 0; mask_wdata = '0;
    pend_clr = '0; eret = 0;
    cycle(); cycle();
    check("reset_pending", AW'(pending), 0);
    check("reset_intSig",  AW'(intSig), 0);

    // Scenario 1: single interrupt on line 2.
    reset = 0; int_en_set = 1; mask_we = 1; mask_wdata = 4'b1111;
    cycle();
    idle_inputs();
    for (int i = 0; i < 5; i++) cycle();
    irq = 4'b0100; cycle();
    check("s1_pending", AW'(pending), 32'h4);
    check("s1_no_int_yet", AW'(intSig), 0);
    irq = '0; cycle();
    check("s1_intSig", AW'(intSig), 1);
    check("s1_cause", AW'(cause), 2);
    pc_addr = 40; cycle();
    check("s1_epc", epc, 40);
    check("s1_in_service", AW'(in_service), 1);
    check("s1_intSig_off", AW'(intSig), 0);
    check("s1_pending_clr", AW'(pending), 0);

    // Scenario 2: simultaneous lines 3 and 1, lowest index first.
    eret = 1; cycle();
    check("s2_ret_valid", AW'(ret_valid), 1);
    check("s2_ret_addr", ret_addr, 40);
    eret = 0; irq = 4'b1010; cycle();
    irq = '0; cycle();
    check("s2_first_cause", AW'(cause), 1);
    check("s2_first_int", AW'(intSig), 1);
    pc_addr = 40; cycle();
    cycle();
    eret = 1; cycle();
    check("s2_ret_pulse", AW'(ret_valid), 1);
    check("s2_ret_addr2", ret_addr, 40);
    eret = 0; cycle();
    check("s2_second_int", AW'(intSig), 1);
    check("s2_second_cause", AW'(cause), 3);
    pc_addr = 77; cycle();
    eret = 1; cycle();
    eret = 0;

    // Scenario 3: masked line latches but does not fire until unmasked.
    mask_we = 1; mask_wdata = 4'b0000; cycle();
    mask_we = 0; irq = 4'b0001; cycle();
    check("s3_pending0", AW'(pending[0]), 1);
    irq = '0; cycle(); cycle();
    check("s3_masked_no_int", AW'(intSig), 0);
    mask_we = 1; mask_wdata = 4'b0001; cycle();
    mask_we = 0; cycle();
    check("s3_unmask_int", AW'(intSig), 1);
    pc_addr = 88; cycle();

    // Scenario 4: no redirect while in service; eret in IDLE ignored.
    irq = 4'b0001; cycle();
    irq = '0;
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("s4_blocked", AW'(intSig), 0);
    end
    eret = 1; cycle();
    eret = 0; cycle();
    check("s4_refire", AW'(intSig), 1);
    cycle();
    eret = 1; cycle();
    eret = 1; cycle();
    check("s4_eret_idle", AW'(ret_valid), 0);
    eret = 0; int_en_set = 1; int_en_clr = 1; cycle();
    check("s4_clr_wins", AW'(int_enabled), 0);
    idle_inputs();

    // Scenario 5: edge beats clear; reset mid-service.
    irq = 4'b0010; pend_clr = 4'b0010; cycle();
    check("s5_edge_wins", AW'(pending[1]), 1);
    irq = '0; pend_clr = '0;
    int_en_set = 1; mask_we = 1; mask_wdata = 4'b1111; cycle();
    idle_inputs(); cycle();
    check("s5_int", AW'(intSig), 1);
    pc_addr = 32'hdead_beef; cycle();
    check("s5_in_service", AW'(in_service), 1);
    reset = 1; cycle();
    check("s5_rst_in_service", AW'(in_service), 0);
    check("s5_rst_epc", epc, 0);
    check("s5_rst_en", AW'(int_enabled), 0);
    reset = 0;

    // Randomized run.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      irq        = ($urandom_range(0, 2) == 0) ? N'($urandom) : irq;
      pc_addr    = $urandom;
      int_en_set = ($urandom_range(0, 3) == 0);
      int_en_clr = ($urandom_range(0, 15) == 0);
      mask_we    = ($urandom_range(0, 7) == 0);
      mask_wdata = N'($urandom);
      pend_clr   = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      eret       = ($urandom_range(0, 5) == 0);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
